// File: rtl/imem_pkg.sv
// Shared instruction-memory definitions, used by the loader and by fetch.
//   INSTR_SIZE      instruction width in bits (multiple of 8)
//   ADDR_SIZE       byte-address width, equal to the PC width
//   BYTES_PER_INSTR stream bytes per instruction
//   loader_state_t  loader FSM states
package imem_pkg;

  localparam int unsigned INSTR_SIZE      = 24;
  localparam int unsigned ADDR_SIZE       = INSTR_SIZE + 8;
  localparam int unsigned BYTES_PER_INSTR = INSTR_SIZE / 8;

  // Width of the header length field and of the instruction counter.
  localparam int unsigned COUNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    WRITE,
    CSUM,
    DONE
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs stream bytes, MSB first, into one instruction word.
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   clr_i    clear shift register and byte counter
//   shift_i  shift byte_i in from the right
//   byte_i   stream byte
//   last_o   the next shifted byte completes the instruction
//   data_o   packed instruction; held until the next clr_i/shift_i
module imem_loader_byte_packer
  import imem_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  shift_i,
  input  logic [7:0]            byte_i,
  output logic                  last_o,
  output logic [INSTR_SIZE-1:0] data_o
);

  localparam int unsigned CntW = (BYTES_PER_INSTR > 1) ? $clog2(BYTES_PER_INSTR) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BYTES_PER_INSTR - 1);

  logic [INSTR_SIZE-1:0] data_q, data_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  assign last_o = (cnt_q == LastCnt);
  assign data_o = data_q;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (shift_i) begin
      // Older bytes move towards the MSB; overflow bits fall off the top.
      data_d = INSTR_SIZE'({data_q, byte_i});
      cnt_d  = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-RAM writer. Receives a length-prefixed byte stream, packs it into
// instructions and writes them at byte addresses 0, 4, 8, ... while holding the core.
// Optional trailer checksum: define IMEM_LOADER_CHECKSUM_EN.
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   load_start_i  start a load (sampled only in IDLE)
//   byte_valid_i  stream byte offered
//   byte_data_i   stream byte
//   byte_ready_o  loader accepts a byte this cycle
//   wr_en_o       one-cycle RAM write strobe
//   wr_addr_o     RAM byte address
//   wr_data_o     packed instruction
//   cpu_hold_o    holds PC and pipeline during a load
//   load_done_o   one-cycle pulse at end of load
//   len_err_o     sticky: header count exceeded DEPTH
//   cksum_err_o   sticky: trailer mismatch (IMEM_LOADER_CHECKSUM_EN only)
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_start_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  wr_en_o,
  output logic [ADDR_SIZE-1:0]  wr_addr_o,
  output logic [INSTR_SIZE-1:0] wr_data_o,
  output logic                  cpu_hold_o,
  output logic                  load_done_o,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic                  cksum_err_o,
`endif
  output logic                  len_err_o
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t AfterPayload = CSUM;
`else
  localparam loader_state_t AfterPayload = DONE;
`endif

  loader_state_t        state_q, state_d;
  logic [7:0]           n_hi_q, n_hi_d;
  logic [COUNT_W-1:0]   n_q, n_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 len_err_q, len_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]           xor_q, xor_d;
  logic                 cksum_err_q, cksum_err_d;
`endif

  logic xfer;
  logic pk_clr, pk_shift, pk_last;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign byte_ready_o = state_q inside {HDR0, HDR1, DATA, CSUM};
  assign cksum_err_o  = cksum_err_q;
`else
  assign byte_ready_o = state_q inside {HDR0, HDR1, DATA};
`endif

  assign xfer        = byte_valid_i & byte_ready_o;
  assign pk_shift    = (state_q == DATA) & xfer;
  assign cpu_hold_o  = state_q inside {HDR0, HDR1, DATA, WRITE, CSUM};
  assign load_done_o = (state_q == DONE);
  assign len_err_o   = len_err_q;

  // Instructions beyond the RAM are still packed but never written.
  assign wr_en_o   = (state_q == WRITE) && (32'(count_q) < DEPTH);
  assign wr_addr_o = ADDR_SIZE'({count_q, 2'b00});

  imem_loader_byte_packer u_byte_packer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (pk_clr),
    .shift_i (pk_shift),
    .byte_i  (byte_data_i),
    .last_o  (pk_last),
    .data_o  (wr_data_o)
  );

  always_comb begin
    state_d   = state_q;
    n_hi_d    = n_hi_q;
    n_d       = n_q;
    count_d   = count_q;
    len_err_d = len_err_q;
    pk_clr    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d       = xor_q;
    cksum_err_d = cksum_err_q;
    if (xfer && (state_q != CSUM)) begin
      xor_d = xor_q ^ byte_data_i;
    end
`endif

    unique case (state_q)
      IDLE: begin
        if (load_start_i) begin
          state_d   = HDR0;
          count_d   = '0;
          len_err_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d       = '0;
          cksum_err_d = 1'b0;
`endif
        end
      end
      HDR0: begin
        if (xfer) begin
          n_hi_d  = byte_data_i;
          state_d = HDR1;
        end
      end
      HDR1: begin
        if (xfer) begin
          n_d = {n_hi_q, byte_data_i};
          if (n_d == '0) begin
            state_d = AfterPayload;
          end else begin
            state_d = DATA;
            pk_clr  = 1'b1;
          end
          if (32'(n_d) > DEPTH) begin
            len_err_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (xfer && pk_last) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        count_d = count_q + 1'b1;
        if (count_d < n_q) begin
          state_d = DATA;
          pk_clr  = 1'b1;
        end else begin
          state_d = AfterPayload;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (xfer) begin
          if (byte_data_i != xor_q) begin
            cksum_err_d = 1'b1;
          end
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      n_hi_q    <= '0;
      n_q       <= '0;
      count_q   <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_hi_q    <= n_hi_d;
      n_q       <= n_d;
      count_q   <= count_d;
      len_err_q <= len_err_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xor_q       <= '0;
      cksum_err_q <= 1'b0;
    end else begin
      xor_q       <= xor_d;
      cksum_err_q <= cksum_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader, built with DEPTH=2 so the overflow case is reachable.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int unsigned Depth = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  load_start = 1'b0;
  logic                  byte_valid = 1'b0;
  logic [7:0]            byte_data = 8'h00;
  logic                  byte_ready, wr_en, cpu_hold, load_done, len_err;
  logic [ADDR_SIZE-1:0]  wr_addr;
  logic [INSTR_SIZE-1:0] wr_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic                  cksum_err;
  localparam int         TrailerBytes = 1;
`else
  localparam int         TrailerBytes = 0;
`endif

  imem_loader #(
    .DEPTH (Depth)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_start_i (load_start),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .cpu_hold_o   (cpu_hold),
    .load_done_o  (load_done),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .cksum_err_o  (cksum_err),
`endif
    .len_err_o    (len_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write and handshake monitor, sampled on the falling edge.
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          xfers = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid && byte_ready) xfers++;
      if (wr_en) begin
        wa.push_back(32'(wr_addr));
        wd.push_back(32'(wr_data));
        check_eq("ready_in_write", 32'(byte_ready), 32'd0);
        check_eq("hold_in_write", 32'(cpu_hold), 32'd1);
      end
    end
  end

  logic [7:0] xacc;
  int         wbase, xbase, lat;

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    while (!byte_ready && t < 40) begin
      t++;
      @(negedge clk);
    end
    if (!byte_ready) check_eq("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    xacc = xacc ^ b;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    xacc  = 8'h00;
    wbase = wa.size();
    xbase = xfers;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 1;
    @(negedge clk);
    while (!load_done && cycles < 60) begin
      cycles++;
      @(negedge clk);
    end
    check_eq("done_seen", 32'(load_done), 32'd1);
    check_eq("hold_at_done", 32'(cpu_hold), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic finish_load(output int cycles);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xacc);
`endif
    wait_done(cycles);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check_eq({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check_eq({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check_eq({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check_eq({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check_eq({tag, "_done"}, 32'(load_done), 32'd0);
    check_eq({tag, "_len_err"}, 32'(len_err), 32'd0);
  endtask

  logic [7:0] s1[8] = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33};
  logic [7:0] s3[5] = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE};

  initial begin
    xacc = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: two instructions
    start_load();
    check_eq("t1_hold_rise", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(s1[i]);
    finish_load(lat);
    check_eq("t1_nwr", 32'(wa.size() - wbase), 32'd2);
    check_eq("t1_addr0", wa[wbase], 32'h0);
    check_eq("t1_data0", wd[wbase], 32'hAABBCC);
    check_eq("t1_addr1", wa[wbase + 1], 32'h4);
    check_eq("t1_data1", wd[wbase + 1], 32'h112233);
    check_eq("t1_len_err", 32'(len_err), 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check_eq("t1_done_lat", 32'(lat), 32'd2);
`endif

    // 2: empty load, done follows the length byte immediately
    start_load();
    send_byte(8'h00);
    send_byte(8'h00);
    finish_load(lat);
    check_eq("t2_done_lat", 32'(lat), 32'd1);
    check_eq("t2_nwr", 32'(wa.size() - wbase), 32'd0);
    check_eq("t2_len_err", 32'(len_err), 32'd0);

    // 3: one instruction, valid low every other cycle
    start_load();
    for (int i = 0; i < 4; i++) begin
      send_byte(s3[i]);
      @(posedge clk);
      #1;
    end
    send_byte(s3[4]);
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    @(negedge clk);
    check_eq("t3_wr_en_lat", 32'(wr_en), 32'd1);
    check_eq("t3_ready_write", 32'(byte_ready), 32'd0);
    check_eq("t3_addr", 32'(wr_addr), 32'h0);
    check_eq("t3_data", 32'(wr_data), 32'hDEADBE);
    byte_valid = 1'b0;
    finish_load(lat);
    check_eq("t3_nwr", 32'(wa.size() - wbase), 32'd1);
    check_eq("t3_xfers", 32'(xfers - xbase), 32'(5 + TrailerBytes));

    // 4: N=3 into a 2-deep RAM
    start_load();
    send_byte(8'h00);
    send_byte(8'h03);
    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    finish_load(lat);
    check_eq("t4_nwr", 32'(wa.size() - wbase), 32'd2);
    check_eq("t4_addr0", wa[wbase], 32'h0);
    check_eq("t4_data0", wd[wbase], 32'h010203);
    check_eq("t4_addr1", wa[wbase + 1], 32'h4);
    check_eq("t4_data1", wd[wbase + 1], 32'h040506);
    check_eq("t4_xfers", 32'(xfers - xbase), 32'(11 + TrailerBytes));
    check_eq("t4_len_err", 32'(len_err), 32'd1);

    // 5: reset mid-load, then a fresh load
    start_load();
    @(negedge clk);
    check_eq("t5_len_err_clr", 32'(len_err), 32'd0);
    @(posedge clk);
    #1;
    send_byte(8'h00);
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t5_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wbase = wa.size();
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_no_wr_after_rst", 32'(wa.size() - wbase), 32'd0);
    start_load();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    finish_load(lat);
    check_eq("t5_nwr", 32'(wa.size() - wbase), 32'd1);
    check_eq("t5_addr", wa[wbase], 32'h0);
    check_eq("t5_data", wd[wbase], 32'hA1B2C3);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 6: trailer checksum good, then bad
    start_load();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h01);
    wait_done(lat);
    check_eq("t6_cksum_good", 32'(cksum_err), 32'd0);
    check_eq("t6_data", 32'(wd[wbase]), 32'h010203);
    start_load();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h00);
    wait_done(lat);
    check_eq("t6_cksum_bad", 32'(cksum_err), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
